// File: rtl/codec_ctrl_responder.sv
// Device side of the 3-wire codec control link with a WM8731-style register file.
// Define CODEC_READBACK_EN to add the registered rd_addr/rd_data read port.
module codec_ctrl_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       frame_err,
  output logic       active,
  output logic [7:0] pd_bits,
  output logic [4:0] lin_vol,
  output logic [4:0] rin_vol,
  output logic [6:0] lhp_vol,
  output logic [6:0] rhp_vol,
  output logic [6:0] aif_fmt,
  output logic [6:0] sr_ctrl,
  output logic [7:0] frames
`ifdef CODEC_READBACK_EN
  ,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data
`endif
);

  localparam int         NUM_REGS   = 10;
  localparam logic [6:0] ADDR_RESET = 7'h0F;

  function automatic logic [8:0] reg_default(input int idx);
    case (idx)
      0, 1:    return 9'h097;
      2, 3:    return 9'h079;
      4:       return 9'h00A;
      5:       return 9'h008;
      6:       return 9'h09F;
      7:       return 9'h00A;
      default: return 9'h000;
    endcase
  endfunction

  // Format/sampling/volume registers are frozen while the interface is active.
  function automatic logic locked_while_active(input logic [6:0] a);
    return a inside {7'h00, 7'h01, 7'h02, 7'h03, 7'h07, 7'h08};
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_rise, cs_rise, mosi_s;

  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d, cnt_upd;
  logic [6:0]  word_addr;
  logic [8:0]  word_data;
  logic        frame_ok, commit, reject;

  logic [8:0] regs_q [NUM_REGS];
  logic [8:0] regs_d [NUM_REGS];

  logic       wr_strobe_q;
  logic [6:0] wr_addr_q;
  logic [8:0] wr_data_q;
  logic       frame_err_q;
  logic [7:0] frames_q;

  // Synchronisers run through reset so the edge detectors start settled on the idle levels.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
    sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
  end

  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign cs_rise  = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    shift_d = shift_q;
    cnt_upd = cnt_q;
    if (sck_rise) begin
      shift_d = {shift_q[14:0], mosi_s};
      if (cnt_q != 5'd31) cnt_upd = cnt_q + 5'd1;
    end

    // A coincident sck edge is already folded into shift_d/cnt_upd here.
    word_addr = shift_d[15:9];
    word_data = shift_d[8:0];
    frame_ok  = (cnt_upd == 5'(WORD_BITS)) &&
                ((word_addr <= 7'h09) || (word_addr == ADDR_RESET));
    commit    = cs_rise && frame_ok;
    reject    = cs_rise && !frame_ok;
    cnt_d     = cs_rise ? 5'd0 : cnt_upd;

    regs_d = regs_q;
    if (commit) begin
      if (word_addr == ADDR_RESET) begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = reg_default(i);
      end else if (!(regs_q[9][0] && locked_while_active(word_addr))) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (word_addr == 7'(i)) regs_d[i] = word_data;
        if (word_data[8] && (word_addr == 7'h00 || word_addr == 7'h01)) begin
          regs_d[0] = word_data;
          regs_d[1] = word_data;
        end
        if (word_data[8] && (word_addr == 7'h02 || word_addr == 7'h03)) begin
          regs_d[2] = word_data;
          regs_d[3] = word_data;
        end
      end
    end
  end

  // NOTE: the register file is a handful of flops with architectural defaults, so it is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      frames_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(i);
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      wr_strobe_q <= commit;
      frame_err_q <= frame_err_q | reject;
      regs_q      <= regs_d;
      if (commit) begin
        wr_addr_q <= word_addr;
        wr_data_q <= word_data;
        frames_q  <= frames_q + 8'd1;
      end
    end
  end

`ifdef CODEC_READBACK_EN
  logic [8:0] rd_mux;
  logic [8:0] rd_data_q;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == 4'(i)) rd_mux = regs_q[i];
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_mux;
  end

  assign rd_data = rd_data_q;
`endif

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign frames    = frames_q;
  assign active    = regs_q[9][0];
  assign pd_bits   = regs_q[6][7:0];
  assign lin_vol   = regs_q[0][4:0];
  assign rin_vol   = regs_q[1][4:0];
  assign lhp_vol   = regs_q[2][6:0];
  assign rhp_vol   = regs_q[3][6:0];
  assign aif_fmt   = regs_q[7][6:0];
  assign sr_ctrl   = regs_q[8][6:0];

endmodule

// File: tb/tb_codec_ctrl_responder.sv
// Self-checking bench for codec_ctrl_responder: directed scenarios plus randomized frames
// compared against a register-level reference model of the codec control port.
module tb_codec_ctrl_responder;

  localparam int HALF = 2;  // sck half period in clk cycles (clk = 4x sck)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       cs = 1'b1;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       frame_err;
  logic       active;
  logic [7:0] pd_bits;
  logic [4:0] lin_vol, rin_vol;
  logic [6:0] lhp_vol, rhp_vol, aif_fmt, sr_ctrl;
  logic [7:0] frames;
`ifdef CODEC_READBACK_EN
  logic [3:0] rd_addr = 4'd0;
  logic [8:0] rd_data;
`endif

  codec_ctrl_responder dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .mosi      (mosi),
    .cs        (cs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .active    (active),
    .pd_bits   (pd_bits),
    .lin_vol   (lin_vol),
    .rin_vol   (rin_vol),
    .lhp_vol   (lhp_vol),
    .rhp_vol   (rhp_vol),
    .aif_fmt   (aif_fmt),
    .sr_ctrl   (sr_ctrl),
    .frames    (frames)
`ifdef CODEC_READBACK_EN
    ,
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the register file as the codec sees it, plus link status.
  int mreg [10];
  int mframes, merr, mwa, mwd;

  function automatic int default_of(int i);
    case (i)
      0, 1:    return 'h097;
      2, 3:    return 'h079;
      4:       return 'h00A;
      5:       return 'h008;
      6:       return 'h09F;
      7:       return 'h00A;
      default: return 'h000;
    endcase
  endfunction

  function automatic void model_defaults();
    for (int i = 0; i < 10; i++) mreg[i] = default_of(i);
  endfunction

  function automatic void model_reset();
    model_defaults();
    mframes = 0;
    merr    = 0;
    mwa     = 0;
    mwd     = 0;
  endfunction

  // Returns 1 when the frame is expected to produce a write strobe.
  function automatic int model_commit(int nbits, int addr, int data);
    if (nbits != 16 || !(addr <= 9 || addr == 15)) begin
      merr = 1;
      return 0;
    end
    mframes = (mframes + 1) % 256;
    mwa = addr;
    mwd = data;
    if (addr == 15) begin
      model_defaults();
    end else if ((mreg[9] & 1) == 1 && addr inside {0, 1, 2, 3, 7, 8}) begin
      // frozen while active
    end else begin
      mreg[addr] = data;
      if (((data >> 8) & 1) == 1 && addr <= 1) begin
        mreg[0] = data;
        mreg[1] = data;
      end
      if (((data >> 8) & 1) == 1 && (addr == 2 || addr == 3)) begin
        mreg[2] = data;
        mreg[3] = data;
      end
    end
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".active"},    32'(active),    32'(mreg[9] & 'h1));
    chk({tag, ".pd_bits"},   32'(pd_bits),   32'(mreg[6] & 'hFF));
    chk({tag, ".lin_vol"},   32'(lin_vol),   32'(mreg[0] & 'h1F));
    chk({tag, ".rin_vol"},   32'(rin_vol),   32'(mreg[1] & 'h1F));
    chk({tag, ".lhp_vol"},   32'(lhp_vol),   32'(mreg[2] & 'h7F));
    chk({tag, ".rhp_vol"},   32'(rhp_vol),   32'(mreg[3] & 'h7F));
    chk({tag, ".aif_fmt"},   32'(aif_fmt),   32'(mreg[7] & 'h7F));
    chk({tag, ".sr_ctrl"},   32'(sr_ctrl),   32'(mreg[8] & 'h7F));
    chk({tag, ".frames"},    32'(frames),    32'(mframes));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(merr));
    chk({tag, ".wr_addr"},   32'(wr_addr),   32'(mwa));
    chk({tag, ".wr_data"},   32'(wr_data),   32'(mwd));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cs    = 1'b1;
    sck   = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Sends nbits MSB-first from {addr,data}; merge_last raises the final sck and cs together.
  task automatic send(input string tag, input int nbits, input int addr, input int data,
                      input bit merge_last);
    logic [15:0] word;
    int exp_strobe, seen, first;
    word = {7'(addr), 9'(data)};
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? word[15 - i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (merge_last && i == nbits - 1) begin
        sck = 1'b1;
        cs  = 1'b1;
      end else begin
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
      end
    end
    if (!merge_last) begin
      repeat (HALF) @(negedge clk);
      cs = 1'b1;
    end
    exp_strobe = model_commit(nbits, addr, data);
    seen  = 0;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (wr_strobe === 1'b1) begin
        seen++;
        if (first == 0) first = k;
      end
    end
    chk({tag, ".strobe_count"}, 32'(seen), 32'(exp_strobe));
    if (exp_strobe == 1) chk({tag, ".strobe_latency"}, 32'(first), 32'd3);
    sck = 1'b0;
    repeat (HALF) @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, d, n;

    do_reset();
    check_all("reset");
    chk("reset.wr_strobe", 32'(wr_strobe), 32'd0);

    send("t1_softreset", 16, 'h0F, 'h000, 1'b0);
    chk("t1.wr_addr_0F", 32'(wr_addr), 32'h0F);
    chk("t1.frames_1", 32'(frames), 32'd1);

    send("t2_lrinboth", 16, 'h00, 'h11F, 1'b0);
    chk("t2.lin_vol_31", 32'(lin_vol), 32'd31);
    chk("t2.rin_vol_31", 32'(rin_vol), 32'd31);

    send("t3_fmt", 16, 'h07, 'h04B, 1'b0);
    send("t3_activate", 16, 'h09, 'h001, 1'b0);
    send("t3_fmt_locked", 16, 'h07, 'h00A, 1'b0);
    chk("t3.aif_fmt_held", 32'(aif_fmt), 32'h4B);
    send("t3_pd_while_active", 16, 'h06, 'h055, 1'b0);
    send("t3_deactivate", 16, 'h09, 'h000, 1'b0);
    send("t3_hpboth", 16, 'h03, 'h17F, 1'b0);

    send("t4_short", 15, 'h06, 'h000, 1'b0);
    chk("t4.frame_err", 32'(frame_err), 32'd1);
    send("t4_recover", 16, 'h06, 'h000, 1'b0);
    chk("t4.pd_bits_0", 32'(pd_bits), 32'd0);

    send("coincident_edge", 16, 'h08, 'h055, 1'b1);
    send("long_frame", 40, 'h08, 'h000, 1'b0);

    do_reset();
    check_all("reset2");
    send("t5_bad_addr", 16, 'h0C, 'h123, 1'b0);
    chk("t5.frame_err", 32'(frame_err), 32'd1);

    // Reset in the middle of a frame: partial bits must be discarded.
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mosi = 1'($urandom);
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("t5_midreset");
    chk("t5.strobe_after_reset", 32'(wr_strobe), 32'd0);
    send("t5_after_reset", 16, 'h02, 'h065, 1'b0);

    // Randomized mix of legal, illegal and mis-sized frames.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0:       n = 15;
        1:       n = 17;
        default: n = 16;
      endcase
      a = $urandom_range(0, 15);
      d = $urandom_range(0, 511);
      send("rand_mix", n, a, d, ($urandom_range(0, 3) == 0));
    end

    // 256 valid frames from reset wrap the frame counter back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      a = $urandom_range(0, 10);
      if (a == 10) a = 15;
      d = $urandom_range(0, 511);
      send("rand_valid", 16, a, d, 1'b0);
    end
    chk("t6.frames_wrap", 32'(frames), 32'd0);

`ifdef CODEC_READBACK_EN
    @(negedge clk);
    rd_addr = 4'd2;
    @(negedge clk);
    chk("t6.rd_data_r2", 32'(rd_data), 32'(mreg[2]));
    rd_addr = 4'd12;
    @(negedge clk);
    chk("t6.rd_data_r12", 32'(rd_data), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
